// File: rtl/regfile_pkg.sv
// Shared constants for the parametrised nano-cpu register file: default width,
// ABI register indices and the flattened-port slice helper.
package regfile_pkg;

    localparam int XLEN_DEFAULT = 32;

    localparam int REG_ZERO = 0;
    localparam int REG_RA   = 1;
    localparam int REG_SP   = 2;
    localparam int REG_GP   = 3;
    localparam int REG_TP   = 4;
    localparam int REG_T0   = 5;
    localparam int REG_T1   = 6;
    localparam int REG_T2   = 7;
    localparam int REG_S0   = 8;
    localparam int REG_S1   = 9;
    localparam int REG_A0   = 10;
    localparam int REG_A1   = 11;
    localparam int REG_A2   = 12;
    localparam int REG_A3   = 13;
    localparam int REG_A4   = 14;
    localparam int REG_A5   = 15;
    localparam int REG_A6   = 16;
    localparam int REG_A7   = 17;

    // Low bit of port idx inside a flattened bus of width-bit fields.
    function automatic int slice_lo(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: issue reserves a destination, writeback releases it.
// Owns the busy vector, the reserve handshake and the busy counter.
module regfile_scoreboard #(
    parameter  int NUM_REGS = 32,
    localparam int AW       = $clog2(NUM_REGS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_valid,
    input  logic [AW-1:0]       wr_select,
    input  logic                rsv_valid,
    input  logic [AW-1:0]       rsv_select,
    output logic [NUM_REGS-1:0] busy,
    output logic                rsv_ready,
    output logic [AW:0]         busy_count
);

    localparam logic [AW:0] CNT_ONE = (AW+1)'(1);

    logic rsv_set;
    logic wr_clr;
    logic cnt_inc;
    logic cnt_dec;

    // A same-cycle writeback of the selected register frees it for re-issue.
    assign rsv_ready = !busy[rsv_select] || (wr_valid && (wr_select == rsv_select));
    assign rsv_set   = rsv_valid && rsv_ready && (rsv_select != '0);
    assign wr_clr    = wr_valid && (wr_select != '0);

    assign cnt_inc = rsv_set && !busy[rsv_select];
    assign cnt_dec = wr_clr && busy[wr_select]
                     && !(rsv_set && (rsv_select == wr_select));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy       <= '0;
            busy_count <= '0;
        end else begin
            if (wr_clr)
                busy[wr_select] <= 1'b0;
            // Placed after the clear so a same-index reserve wins.
            if (rsv_set)
                busy[rsv_select] <= 1'b1;
            if (cnt_inc && !cnt_dec)
                busy_count <= busy_count + CNT_ONE;
            else if (cnt_dec && !cnt_inc)
                busy_count <= busy_count - CNT_ONE;
        end
    end

endmodule

// File: rtl/register_file_sb.sv
// Parametrised integer register file with busy scoreboard and N read ports.
// Define REGFILE_BYPASS_EN to forward same-cycle writeback data to the read ports.
module register_file_sb
    import regfile_pkg::*;
#(
    parameter  int XLEN     = XLEN_DEFAULT,
    parameter  int NUM_REGS = 32,
    parameter  int NUM_READ = 2,
    localparam int AW       = $clog2(NUM_REGS)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_valid,
    input  logic [AW-1:0]            wr_select,
    input  logic [XLEN-1:0]          wr_data,
    input  logic [NUM_READ*AW-1:0]   rd_select,
    output logic [NUM_READ*XLEN-1:0] rd_data,
    output logic [NUM_READ-1:0]      rd_busy,
    input  logic                     rsv_valid,
    input  logic [AW-1:0]            rsv_select,
    output logic                     rsv_ready,
    output logic [AW:0]              busy_count
);

    logic [XLEN-1:0]     regs [NUM_REGS];
    logic [NUM_REGS-1:0] busy;

    regfile_scoreboard #(
        .NUM_REGS (NUM_REGS)
    ) u_scoreboard (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_valid   (wr_valid),
        .wr_select  (wr_select),
        .rsv_valid  (rsv_valid),
        .rsv_select (rsv_select),
        .busy       (busy),
        .rsv_ready  (rsv_ready),
        .busy_count (busy_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NUM_REGS; r++)
                regs[r] <= '0;
        end else if (wr_valid && (wr_select != '0)) begin
            regs[wr_select] <= wr_data;
        end
    end

    for (genvar i = 0; i < NUM_READ; i++) begin : g_read
        logic [AW-1:0]   sel;
        logic [XLEN-1:0] data;
        logic            bsy;
`ifdef REGFILE_BYPASS_EN
        logic            hit;

        // Gated by reset so forwarding cannot leak data while the file is cleared.
        assign hit = rst_n && wr_valid && (wr_select == sel) && (sel != '0);
`endif

        assign sel = rd_select[slice_lo(i, AW) +: AW];

        always_comb begin
            data = '0;
            bsy  = 1'b0;
            if (sel != '0) begin
                data = regs[sel];
                bsy  = busy[sel];
            end
`ifdef REGFILE_BYPASS_EN
            if (hit) begin
                data = wr_data;
                bsy  = 1'b0;
            end
`endif
        end

        assign rd_data[slice_lo(i, XLEN) +: XLEN] = data;
        assign rd_busy[i]                         = bsy;
    end

endmodule
